// File: rtl/aes_avalon_regs.sv
// Avalon-MM register front end for the AES decryption core: key/ciphertext staging,
// START handshake, result capture on AES_DONE, and a decrypt-latency counter.
module aes_avalon_regs #(
    parameter int CNT_W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_DEC,
    output logic [31:0]  EXPORT_DATA
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_nx;
    logic [31:0]      key_r [4];
    logic [31:0]      msg_r [4];
    logic [31:0]      dec_r [4];
    logic [CNT_W-1:0] cycles;
    logic             start, start_nx, done;
    logic             arm, capture, busy;
    logic             wr, rd, ctrl_wr;
    logic [31:0]      rdata, cyc_rd;

    assign wr      = AVL_CS & AVL_WRITE;
    assign rd      = AVL_CS & AVL_READ;
    assign ctrl_wr = wr & (AVL_ADDR == 4'd14) & AVL_BYTE_EN[0];
    assign busy    = (state == RUN);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // Outside IDLE, START can only be cleared: 1->1 is a no-op and 0->1 is not honoured.
    always_comb begin
        state_nx = state;
        start_nx = start;
        arm      = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && AVL_WRITEDATA[0]) begin
                    start_nx = 1'b1;
                    arm      = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (ctrl_wr) start_nx = start & AVL_WRITEDATA[0];
                if (AES_DONE) begin
                    capture  = 1'b1;
                    state_nx = start_nx ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (ctrl_wr) start_nx = start & AVL_WRITEDATA[0];
                if (!start_nx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                key_r[i] <= '0;
                msg_r[i] <= '0;
                dec_r[i] <= '0;
            end
            cycles       <= '0;
            start        <= 1'b0;
            done         <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            start <= start_nx;
            // Key/ciphertext are frozen while the core is consuming them.
            if (wr && !busy && !AVL_ADDR[3]) begin
                for (int b = 0; b < 4; b++) begin
                    if (AVL_BYTE_EN[b]) begin
                        if (AVL_ADDR[2]) msg_r[AVL_ADDR[1:0]][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                        else             key_r[AVL_ADDR[1:0]][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                    end
                end
            end
            if (arm) begin
                done   <= 1'b0;
                cycles <= '0;
            end else if (busy && cycles != {CNT_W{1'b1}}) begin
                cycles <= cycles + 1'b1;
            end
            // Placed after the arm clear so a capture always wins on DONE.
            if (capture) begin
                done <= 1'b1;
                for (int i = 0; i < 4; i++) dec_r[i] <= AES_MSG_DEC[32*(3-i) +: 32];
            end
            if (rd) AVL_READDATA <= rdata;
        end
    end

    always_comb begin
        cyc_rd              = '0;
        cyc_rd[CNT_W-1:0]   = cycles;
        rdata               = '0;
        case (AVL_ADDR[3:2])
            2'd0: rdata = key_r[AVL_ADDR[1:0]];
            2'd1: rdata = msg_r[AVL_ADDR[1:0]];
            2'd2: rdata = dec_r[AVL_ADDR[1:0]];
            default: begin
                case (AVL_ADDR[1:0])
                    2'd0:    rdata = cyc_rd;
                    2'd2:    rdata = {31'b0, start};
                    2'd3:    rdata = {30'b0, busy, done};
                    default: rdata = '0;
                endcase
            end
        endcase
    end

    assign AES_KEY     = {key_r[0], key_r[1], key_r[2], key_r[3]};
    assign AES_MSG_ENC = {msg_r[0], msg_r[1], msg_r[2], msg_r[3]};
    assign AES_START   = start;
    assign EXPORT_DATA = {dec_r[0][31:16], dec_r[3][15:0]};
endmodule

// File: tb/tb_aes_avalon_regs.sv
// Self-checking bench for aes_avalon_regs: directed plan scenarios plus randomized
// register traffic and decrypt runs checked against a word-level register model.
module tb_aes_avalon_regs;
    logic         CLK = 1'b0;
    logic         RESET, AVL_CS, AVL_READ, AVL_WRITE, AES_START, AES_DONE;
    logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
    logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
    logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;

    aes_avalon_regs #(.CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
        .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC), .AES_START(AES_START),
        .AES_DONE(AES_DONE), .AES_MSG_DEC(AES_MSG_DEC), .EXPORT_DATA(EXPORT_DATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] m_key [4];
    logic [31:0] m_msg [4];
    logic [31:0] m_dec [4];
    bit          m_busy = 0;
    int          p_s;
    logic [31:0] rv;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [127:0] cat4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        tick();
        AVL_CS = 0; AVL_WRITE = 0;
        if (a < 4 && !m_busy)      m_key[a]     = merge(m_key[a], d, be);
        else if (a < 8 && !m_busy) m_msg[a - 4] = merge(m_msg[a - 4], d, be);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        tick();
        AVL_CS = 0; AVL_READ = 0;
        d = AVL_READDATA;
    endtask

    task automatic start_run();
        bus_write(4'd14, 32'h1, 4'h1);
        p_s    = cyc;
        m_busy = 1;
    endtask

    // Core model: DONE is sampled on the lat-th edge after the START write edge.
    task automatic pulse_done(input int lat, input logic [127:0] dec, input bit wr_ctrl);
        n_checks++;
        if (cyc > p_s + lat - 1) begin
            n_fail++;
            $display("FAIL pulse_timing: now %0d, required at most %0d", cyc, p_s + lat - 1);
        end
        while (cyc < p_s + lat - 1) tick();
        AES_DONE = 1; AES_MSG_DEC = dec;
        if (wr_ctrl) begin
            AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 4'd14; AVL_WRITEDATA = 32'h0; AVL_BYTE_EN = 4'hF;
        end
        tick();
        AES_DONE = 0; AVL_CS = 0; AVL_WRITE = 0;
        AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
        m_busy = 0;
        for (int i = 0; i < 4; i++) m_dec[i] = dec[127 - 32*i -: 32];
    endtask

    task automatic test_reset();
        RESET = 1;
        repeat (3) tick();
        RESET = 0;
        n_checks++;
        if (AES_START !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", AES_START); end
        n_checks++;
        if (AES_KEY !== 128'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0", AES_KEY); end
        for (int a = 0; a < 16; a++) begin
            bus_read(a[3:0], rv);
            n_checks++;
            if (rv !== 32'h0) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want 00000000", a, rv); end
        end
    endtask

    task automatic test_byte_en();
        logic [127:0] d;
        bus_write(4'd0, 32'hFFFF_FFFF, 4'b0101);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'd0;
        n_checks++;
        if (AVL_READDATA !== 32'h0) begin n_fail++; $display("FAIL read_latency_pre: got %h want 00000000", AVL_READDATA); end
        tick();
        AVL_CS = 0; AVL_READ = 0; AVL_ADDR = 4'd5;
        n_checks++;
        if (AVL_READDATA !== 32'h00FF00FF) begin n_fail++; $display("FAIL byte_en_read: got %h want 00ff00ff", AVL_READDATA); end
        repeat (2) tick();
        n_checks++;
        if (AVL_READDATA !== 32'h00FF00FF) begin n_fail++; $display("FAIL read_hold: got %h want 00ff00ff", AVL_READDATA); end
        start_run();
        bus_write(4'd0, 32'hFFFF_FFFF, 4'hF);
        bus_read(4'd0, rv);
        n_checks++;
        if (rv !== 32'h00FF00FF) begin n_fail++; $display("FAIL write_in_run: got %h want 00ff00ff", rv); end
        n_checks++;
        if (AES_KEY[127:96] !== 32'h00FF00FF) begin n_fail++; $display("FAIL key_in_run: got %h want 00ff00ff", AES_KEY[127:96]); end
        d = {$urandom, $urandom, $urandom, $urandom};
        pulse_done(12, d, 0);
        bus_write(4'd14, 32'h0, 4'h1);
    endtask

    task automatic test_key_start();
        bus_write(4'd0, 32'h00010203, 4'hF);
        bus_write(4'd1, 32'h04050607, 4'hF);
        bus_write(4'd2, 32'h08090a0b, 4'hF);
        bus_write(4'd3, 32'h0c0d0e0f, 4'hF);
        for (int i = 4; i < 8; i++) bus_write(i[3:0], $urandom, 4'hF);
        start_run();
        n_checks++;
        if (AES_KEY !== 128'h000102030405060708090a0b0c0d0e0f) begin n_fail++; $display("FAIL key_out: got %h", AES_KEY); end
        n_checks++;
        if (AES_MSG_ENC !== cat4(m_msg[0], m_msg[1], m_msg[2], m_msg[3])) begin n_fail++; $display("FAIL msg_enc_out: got %h", AES_MSG_ENC); end
        n_checks++;
        if (AES_START !== 1'b1) begin n_fail++; $display("FAIL start_out: got %b want 1", AES_START); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h2) begin n_fail++; $display("FAIL status_busy: got %h want 2", rv); end
    endtask

    task automatic test_decrypt();
        logic [31:0] exp_w [4];
        exp_w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        pulse_done(40, 128'h00112233445566778899aabbccddeeff, 0);
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(8 + i), rv);
            n_checks++;
            if (rv !== exp_w[i]) begin n_fail++; $display("FAIL dec_word[%0d]: got %h want %h", i, rv, exp_w[i]); end
        end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h1) begin n_fail++; $display("FAIL status_done: got %h want 1", rv); end
        bus_read(4'd12, rv);
        n_checks++;
        if (rv !== 32'd40) begin n_fail++; $display("FAIL cycles_40: got %0d want 40", rv); end
        n_checks++;
        if (EXPORT_DATA !== 32'h0011eeff) begin n_fail++; $display("FAIL export: got %h want 0011eeff", EXPORT_DATA); end
        bus_write(4'd14, 32'h1, 4'h1);
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h1 || AES_START !== 1'b1) begin n_fail++; $display("FAIL hold_restart: status %h start %b want 1/1", rv, AES_START); end
        bus_write(4'd14, 32'h0, 4'h1);
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h1 || AES_START !== 1'b0) begin n_fail++; $display("FAIL hold_release: status %h start %b want 1/0", rv, AES_START); end
    endtask

    task automatic test_done_with_ctrl();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        int lat = $urandom_range(15, 30);
        start_run();
        pulse_done(lat, d, 1);
        n_checks++;
        if (AES_START !== 1'b0) begin n_fail++; $display("FAIL coll_start: got %b want 0", AES_START); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h1) begin n_fail++; $display("FAIL coll_status: got %h want 1", rv); end
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(8 + i), rv);
            n_checks++;
            if (rv !== m_dec[i]) begin n_fail++; $display("FAIL coll_dec[%0d]: got %h want %h", i, rv, m_dec[i]); end
        end
        bus_read(4'd12, rv);
        n_checks++;
        if (rv !== 32'(lat)) begin n_fail++; $display("FAIL coll_cycles: got %0d want %0d", rv, lat); end
        start_run();
        bus_read(4'd12, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL rearm_cycles: got %0d want 0", rv); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h2) begin n_fail++; $display("FAIL rearm_status: got %h want 2", rv); end
        pulse_done(20, {$urandom, $urandom, $urandom, $urandom}, 0);
        bus_write(4'd14, 32'h0, 4'h1);
    endtask

    task automatic test_stop_in_run();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        start_run();
        bus_write(4'd14, 32'h0, 4'h1);
        n_checks++;
        if (AES_START !== 1'b0) begin n_fail++; $display("FAIL stop_start: got %b want 0", AES_START); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h2) begin n_fail++; $display("FAIL stop_busy: got %h want 2", rv); end
        pulse_done(25, d, 0);
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h1) begin n_fail++; $display("FAIL stop_status: got %h want 1", rv); end
        AES_DONE = 1; AES_MSG_DEC = ~d;
        tick();
        AES_DONE = 0;
        bus_read(4'd11, rv);
        n_checks++;
        if (rv !== m_dec[3]) begin n_fail++; $display("FAIL idle_done_ignored: got %h want %h", rv, m_dec[3]); end
        bus_read(4'd14, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL ctrl_read: got %h want 0", rv); end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 4; it++) begin
            logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
            int lat = $urandom_range(20, 50);
            for (int k = 0; k < 8; k++) begin
                logic [3:0] a = 4'($urandom_range(0, 15));
                if (a == 4'd14) a = 4'd13;
                bus_write(a, $urandom, 4'($urandom));
            end
            start_run();
            for (int k = 0; k < 3; k++) bus_write(4'($urandom_range(0, 7)), $urandom, 4'hF);
            n_checks++;
            if (AES_KEY !== cat4(m_key[0], m_key[1], m_key[2], m_key[3]) ||
                AES_MSG_ENC !== cat4(m_msg[0], m_msg[1], m_msg[2], m_msg[3]))
            begin n_fail++; $display("FAIL rnd_operands[%0d]: key %h msg %h", it, AES_KEY, AES_MSG_ENC); end
            pulse_done(lat, d, 0);
            for (int i = 0; i < 8; i++) begin
                bus_read(i[3:0], rv);
                n_checks++;
                if (rv !== (i < 4 ? m_key[i] : m_msg[i - 4])) begin n_fail++; $display("FAIL rnd_reg[%0d]: got %h", i, rv); end
            end
            for (int i = 0; i < 4; i++) begin
                bus_read(4'(8 + i), rv);
                n_checks++;
                if (rv !== m_dec[i]) begin n_fail++; $display("FAIL rnd_dec[%0d]: got %h want %h", i, rv, m_dec[i]); end
            end
            bus_read(4'd12, rv);
            n_checks++;
            if (rv !== 32'(lat)) begin n_fail++; $display("FAIL rnd_cycles: got %0d want %0d", rv, lat); end
            bus_read(4'd15, rv);
            n_checks++;
            if (rv !== 32'h1) begin n_fail++; $display("FAIL rnd_status: got %h want 1", rv); end
            n_checks++;
            if (EXPORT_DATA !== {d[127:112], d[15:0]}) begin n_fail++; $display("FAIL rnd_export: got %h", EXPORT_DATA); end
            bus_write(4'd14, 32'h0, 4'h1);
        end
    endtask

    task automatic test_reset_mid_run();
        start_run();
        while (cyc < p_s + 20) tick();
        RESET = 1;
        tick();
        RESET = 0;
        m_busy = 0;
        n_checks++;
        if (AES_START !== 1'b0) begin n_fail++; $display("FAIL rst_run_start: got %b want 0", AES_START); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_run_status: got %h want 0", rv); end
        bus_read(4'd12, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_run_cycles: got %0d want 0", rv); end
        AES_DONE = 1; AES_MSG_DEC = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        tick();
        AES_DONE = 0;
        bus_read(4'd8, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_run_nocapture: got %h want 0", rv); end
        bus_read(4'd15, rv);
        n_checks++;
        if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_run_status2: got %h want 0", rv); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0;
        AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; AES_DONE = 0; AES_MSG_DEC = '0;
        for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_msg[i] = '0; m_dec[i] = '0; end
        @(negedge CLK);
        test_reset();
        test_byte_en();
        test_key_start();
        test_decrypt();
        test_done_with_ctrl();
        test_stop_in_run();
        test_random_runs();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
